// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 definitions: loop cache state encoding and default geometry.
package jtdsp16_pkg;

  localparam int unsigned JTDSP16_DW         = 16;
  localparam int unsigned JTDSP16_LOOP_DEPTH = 15;
  localparam int unsigned JTDSP16_LOOP_NW    = 4;
  localparam int unsigned JTDSP16_LOOP_CNT_W = 7;

  typedef enum logic [1:0] {
    LOOP_IDLE   = 2'd0,
    LOOP_LOAD   = 2'd1,
    LOOP_REPLAY = 2'd2
  } loop_state_t;

endpackage

// File: rtl/jtdsp16_loop_mem.sv
// Loop body storage: synchronous write, asynchronous read, contents not reset.
module jtdsp16_loop_mem #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_loop_cache.sv
// DSP16 hardware loop unit: captures a "do" body while it executes once, then replays it.
// Optional JTDSP16_LOOP_BRK_EN adds the brk port to end a replaying loop early.
module jtdsp16_loop_cache
  import jtdsp16_pkg::*;
#(
  parameter int unsigned DW    = JTDSP16_DW,
  parameter int unsigned DEPTH = JTDSP16_LOOP_DEPTH,
  parameter int unsigned NW    = JTDSP16_LOOP_NW,
  parameter int unsigned CNT_W = JTDSP16_LOOP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             inst_en,
  input  logic             do_start,
  input  logic             redo_start,
  input  logic [NW-1:0]    ni,
  input  logic [CNT_W-1:0] k,
  input  logic [DW-1:0]    rom_dout,
`ifdef JTDSP16_LOOP_BRK_EN
  input  logic             brk,
`endif
  output logic [DW-1:0]    cache_dout,
  output logic             cache_sel,
  output logic             pc_halt,
  output logic             busy,
  output logic             bad_cmd,
  output logic [15:0]      cnt_dout
);

  localparam logic [NW-1:0]    PTR_ONE = NW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  loop_state_t      state;
  logic [NW-1:0]    wr_ptr, rd_ptr, ni_r;
  logic [CNT_W-1:0] k_r, iter, cnt_sel;
  logic             valid, cmd_bad, brk_req, last_wr, last_rd, mem_we;
  logic [DW-1:0]    mem_rd;

`ifdef JTDSP16_LOOP_BRK_EN
  assign brk_req = brk;
`else
  assign brk_req = 1'b0;
`endif

  assign last_wr = (wr_ptr == ni_r - PTR_ONE);
  assign last_rd = (rd_ptr == ni_r - PTR_ONE);
  assign mem_we  = cen & inst_en & (state == LOOP_LOAD);

  // do_start takes priority: a simultaneous redo is judged as a do only
  always_comb begin
    cmd_bad = 1'b0;
    if (do_start || redo_start) begin
      if (state != LOOP_IDLE)
        cmd_bad = 1'b1;
      else if (do_start)
        cmd_bad = (ni == '0) || (32'(ni) > DEPTH) || (k == '0);
      else
        cmd_bad = !valid || (k == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOOP_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ni_r    <= '0;
      k_r     <= '0;
      iter    <= '0;
      valid   <= 1'b0;
      bad_cmd <= 1'b0;
    end else if (cen) begin
      bad_cmd <= cmd_bad;
      case (state)
        LOOP_IDLE: begin
          if (do_start) begin
            if (!cmd_bad) begin
              ni_r   <= ni;
              k_r    <= k;
              wr_ptr <= '0;
              valid  <= 1'b0;
              state  <= LOOP_LOAD;
            end
          end else if (redo_start && !cmd_bad) begin
            rd_ptr <= '0;
            iter   <= k;
            state  <= LOOP_REPLAY;
          end
        end
        LOOP_LOAD: begin
          if (inst_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (last_wr) begin
              valid <= 1'b1;
              if (k_r == CNT_ONE) begin
                state <= LOOP_IDLE;
              end else begin
                rd_ptr <= '0;
                iter   <= k_r - CNT_ONE;
                state  <= LOOP_REPLAY;
              end
            end
          end
        end
        LOOP_REPLAY: begin
          // brk leaves iter at 1 after this step, so at most one more body pass follows
          if (inst_en) begin
            if (last_rd) begin
              rd_ptr <= '0;
              if (iter == CNT_ONE) begin
                iter  <= '0;
                state <= LOOP_IDLE;
              end else begin
                iter <= brk_req ? CNT_ONE : iter - CNT_ONE;
              end
            end else begin
              rd_ptr <= rd_ptr + PTR_ONE;
              if (brk_req) iter <= CNT_ONE;
            end
          end
        end
        default: state <= LOOP_IDLE;
      endcase
    end
  end

  jtdsp16_loop_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (NW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (rom_dout),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );

  always_comb begin
    cnt_sel = '0;
    case (state)
      LOOP_LOAD:   cnt_sel = k_r;
      LOOP_REPLAY: cnt_sel = iter;
      default:     cnt_sel = '0;
    endcase
  end

  assign cache_sel  = (state == LOOP_REPLAY);
  assign pc_halt    = (state == LOOP_REPLAY);
  assign busy       = (state != LOOP_IDLE);
  assign cache_dout = (state == LOOP_REPLAY) ? mem_rd : '0;
  assign cnt_dout   = 16'(cnt_sel);

endmodule

// File: tb/tb_jtdsp16_loop_cache.sv
// Self-checking bench for jtdsp16_loop_cache; expected replay words flow through a queue.
module tb_jtdsp16_loop_cache;

  logic        clk = 1'b0;
  logic        rst_n, cen, inst_en, do_start, redo_start;
  logic [3:0]  ni;
  logic [6:0]  k;
  logic [15:0] rom_dout;
  logic        brk;
  logic [15:0] cache_dout, cnt_dout;
  logic        cache_sel, pc_halt, busy, bad_cmd;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] body[16];

  always #5 clk = ~clk;

  jtdsp16_loop_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .inst_en    (inst_en),
    .do_start   (do_start),
    .redo_start (redo_start),
    .ni         (ni),
    .k          (k),
    .rom_dout   (rom_dout),
`ifdef JTDSP16_LOOP_BRK_EN
    .brk        (brk),
`endif
    .cache_dout (cache_dout),
    .cache_sel  (cache_sel),
    .pc_halt    (pc_halt),
    .busy       (busy),
    .bad_cmd    (bad_cmd),
    .cnt_dout   (cnt_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues do (optionally with a simultaneous redo), feeds n words, queues k-1 replay passes
  task automatic load_body(input int n, input int kk, input logic [15:0] base, input bit with_redo);
    ni = 4'(n); k = 7'(kk); do_start = 1'b1; redo_start = with_redo;
    tick();
    do_start = 1'b0; redo_start = 1'b0;
    chk_cnt++;
    if ({busy, bad_cmd} !== 2'b10) $display("FAIL load_start: busy,bad got %b want 10", {busy, bad_cmd});
    else pass_cnt++;
    chk_cnt++;
    if (cnt_dout !== 16'(kk)) $display("FAIL load_cnt: got %0d want %0d", cnt_dout, kk);
    else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      body[i] = base + 16'(i);
      rom_dout = body[i];
      chk_cnt++;
      if ({cache_sel, pc_halt, cache_dout} !== 18'd0)
        $display("FAIL load_out: sel,halt,dout got %b%b %h want 00 0000", cache_sel, pc_halt, cache_dout);
      else pass_cnt++;
      tick();
    end
    for (int r = 1; r < kk; r++)
      for (int i = 0; i < n; i++) exp_q.push_back(body[i]);
  endtask

  task automatic run_replay(input int count);
    logic [15:0] w;
    for (int i = 0; i < count; i++) begin
      if (exp_q.size() == 0) break;
      w = exp_q.pop_front();
      chk_cnt++;
      if ({cache_sel, pc_halt, cache_dout} !== {2'b11, w})
        $display("FAIL replay_word: sel,halt,dout got %b%b %h want 11 %h", cache_sel, pc_halt, cache_dout, w);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic check_idle(input string name);
    chk_cnt++;
    if ({busy, cache_sel, pc_halt, cache_dout, cnt_dout} !== 35'd0)
      $display("FAIL %s: busy,sel,halt,dout,cnt got %b%b%b %h %0d want 000 0000 0", name,
               busy, cache_sel, pc_halt, cache_dout, cnt_dout);
    else pass_cnt++;
  endtask

  task automatic issue_redo(input int kk);
    k = 7'(kk); redo_start = 1'b1;
    tick();
    redo_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b1; inst_en = 1'b1; do_start = 1'b0; redo_start = 1'b0;
    ni = '0; k = '0; rom_dout = '0; brk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_idle");
    chk_cnt++;
    if (bad_cmd !== 1'b0) $display("FAIL reset_bad: got %b want 0", bad_cmd);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bad_cmds();
    issue_redo(1);
    chk_cnt++;
    if ({bad_cmd, busy} !== 2'b10) $display("FAIL redo_invalid: bad,busy got %b want 10", {bad_cmd, busy});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bad_cmd !== 1'b0) $display("FAIL bad_pulse: got %b want 0", bad_cmd);
    else pass_cnt++;
    ni = 4'd0; k = 7'd3; do_start = 1'b1;
    tick();
    do_start = 1'b0;
    chk_cnt++;
    if ({bad_cmd, busy} !== 2'b10) $display("FAIL do_ni0: bad,busy got %b want 10", {bad_cmd, busy});
    else pass_cnt++;
    ni = 4'd5; k = 7'd0; do_start = 1'b1;
    tick();
    do_start = 1'b0;
    chk_cnt++;
    if ({bad_cmd, busy} !== 2'b10) $display("FAIL do_k0: bad,busy got %b want 10", {bad_cmd, busy});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_do_replay();
    load_body(3, 3, 16'hA000, 1'b0);
    chk_cnt++;
    if (cnt_dout !== 16'd2) $display("FAIL replay_cnt: got %0d want 2", cnt_dout);
    else pass_cnt++;
    run_replay(exp_q.size());
    check_idle("replay_end");
  endtask

  task automatic test_depth();
    load_body(15, 2, 16'h1000, 1'b0);
    run_replay(exp_q.size());
    check_idle("depth_end");
  endtask

  task automatic test_k1_redo();
    load_body(2, 1, 16'h5A00, 1'b0);
    check_idle("k1_no_replay");
    issue_redo(2);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(body[0]);
      exp_q.push_back(body[1]);
    end
    chk_cnt++;
    if (cnt_dout !== 16'd2) $display("FAIL redo_cnt: got %0d want 2", cnt_dout);
    else pass_cnt++;
    run_replay(exp_q.size());
    check_idle("redo_end");
  endtask

  task automatic test_busy_cmd();
    load_body(3, 3, 16'hC000, 1'b0);
    run_replay(1);
    ni = 4'd2; k = 7'd2; do_start = 1'b1;
    run_replay(1);
    do_start = 1'b0;
    chk_cnt++;
    if ({bad_cmd, busy} !== 2'b11) $display("FAIL busy_bad: bad,busy got %b want 11", {bad_cmd, busy});
    else pass_cnt++;
    run_replay(exp_q.size());
    check_idle("busy_end");
    load_body(2, 2, 16'hD000, 1'b1);
    run_replay(exp_q.size());
    check_idle("do_wins_end");
  endtask

  task automatic test_step_hold();
    issue_redo(3);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(body[0]);
      exp_q.push_back(body[1]);
    end
    run_replay(1);
    inst_en = 1'b0;
    repeat (3) begin
      tick();
      chk_cnt++;
      if ({cache_dout, cnt_dout} !== {exp_q[0], 16'd3})
        $display("FAIL hold: dout,cnt got %h %0d want %h 3", cache_dout, cnt_dout, exp_q[0]);
      else pass_cnt++;
    end
    inst_en = 1'b1;
    run_replay(exp_q.size());
    check_idle("hold_end");
  endtask

  task automatic test_reset_mid();
    issue_redo(5);
    chk_cnt++;
    if ({cache_sel, cnt_dout} !== {1'b1, 16'd5}) $display("FAIL rst_pre: sel,cnt got %b %0d want 1 5", cache_sel, cnt_dout);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1 check_idle("rst_async");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    issue_redo(1);
    chk_cnt++;
    if ({bad_cmd, busy} !== 2'b10) $display("FAIL rst_redo: bad,busy got %b want 10", {bad_cmd, busy});
    else pass_cnt++;
    tick();
  endtask

`ifdef JTDSP16_LOOP_BRK_EN
  task automatic test_brk();
    load_body(2, 10, 16'hB000, 1'b0);
    exp_q.delete();
    exp_q.push_back(body[0]);
    run_replay(1);
    brk = 1'b1;
    exp_q.push_back(body[1]);
    run_replay(1);
    brk = 1'b0;
    exp_q.push_back(body[0]);
    exp_q.push_back(body[1]);
    run_replay(exp_q.size());
    check_idle("brk_end");
  endtask
`endif

  initial begin
    test_reset();
    test_bad_cmds();
    test_do_replay();
    test_depth();
    test_k1_redo();
    test_busy_cmd();
    test_step_hold();
`ifdef JTDSP16_LOOP_BRK_EN
    test_brk();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
